pe_bus_arbiter: RTL and testbench
=================================

// Module: pe_bus_arbiter
// PURPOSE
// Central end of the shared PE bus: consumes pipelined PE requests (valid/addr/data + per-PE receive-buffer
// full flags) and drives the single broadcast bus (data, source id, per-PE write strobe, per-PE source pop).
// Sits opposite the per-PE bus pipeline; pipeline latency is compensated internally so no word is lost or duplicated.
// PARAMETERS
// NUM_PE        8   number of PEs on the bus
// DATA_LEN      16  bus data width
// BUS_ADDR_LEN  3   PE index width, >= clog2(NUM_PE)
// PIPE_STAGES   3   register stages each way between PE and arbiter (0 legal)
// SKID_DEPTH    4   receive-buffer slots reserved past 'full' per (dest,src) pair, >=1
// localparams: HOLDOFF = 2*PIPE_STAGES+1 ; RT_LAT = 2*PIPE_STAGES+2
// PORTS
// clk             in   1                     clock
// rstn            in   1                     async active-low reset
// valid_to_bus_p  in   NUM_PE                PE s has a word pending
// addr_to_bus_p   in   BUS_ADDR_LEN x NUM_PE destination PE index of PE s's word
// data_to_bus_p   in   DATA_LEN x NUM_PE     PE s's pending word
// rd_buffer_full_p in  NUM_PE x NUM_PE       [d][s]: PE d's receive buffer for source s full
// data_bus        out  DATA_LEN              granted word
// addr_bus        out  BUS_ADDR_LEN          source PE index of granted word
// wr_to_bus       out  NUM_PE                one-hot write strobe to destination PE
// rd_from_bus     out  NUM_PE                one-hot pop to source PE
// grant_count     out  32                    stats (BUS_ARB_STATS_EN), else 0
// stall_count     out  32                    stats (BUS_ARB_STATS_EN), else 0
// BEHAVIOUR
// - Reset: all outputs 0; rr_ptr=0; holdoff timers, in-flight counters, grant history cleared. Mid-op reset aborts.
// - Eligible(s) at cycle t: valid_to_bus_p[s] & addr_to_bus_p[s]<NUM_PE & holdoff[s]==0
//   & !rd_buffer_full_p[d][s] & inflight[d][s]<SKID_DEPTH, d=addr_to_bus_p[s]. Out-of-range d: never granted.
// - Arbitration: round-robin, search from rr_ptr upward with wrap; at most one grant/cycle; on grant rr_ptr<=s+1 mod NUM_PE.
// - Grant of s->d at t: at t+1 data_bus=data_to_bus_p[s], addr_bus=s, wr_to_bus=1<<d, rd_from_bus=1<<s; all strobes
//   single-cycle; no grant -> wr_to_bus=rd_from_bus=0, data_bus/addr_bus hold last value.
// - Source holdoff: granted s ineligible for cycles t+1..t+HOLDOFF (stale valid/data still in pipeline).
// - In-flight: inflight[d][s] +1 on grant, -1 RT_LAT cycles later (delayed grant history); simultaneous +1/-1 -> unchanged;
//   never exceeds SKID_DEPTH, never underflows.
// - Self-send (d==s) legal. PIPE_STAGES=0: HOLDOFF=1, RT_LAT=2, same rules.
// - Receivers must raise full with >=SKID_DEPTH free slots remaining; arbiter then never overflows a buffer.
// CONFIGURATION
// BUS_ARB_STATS_EN defined: grant_count +1 per grant; stall_count +1 per cycle with any valid_to_bus_p bit set
//   but no grant; both saturate at 2^32-1, reset to 0.
// Not defined: counters not built; grant_count=stall_count=0 constantly. Arbitration identical either way.
// TESTING (NUM_PE=8, DATA_LEN=16, PIPE_STAGES=3, SKID_DEPTH=4)
// 1 Reset: rstn=0 with valids set -> all outputs 0; release -> first grant to lowest eligible PE from rr_ptr=0.
// 2 Single send: PE2 valid, addr=5, data=16'hBEEF held -> exactly one pulse: wr_to_bus=8'h20, rd_from_bus=8'h04,
//   addr_bus=2, data_bus=BEEF; PE2 not regranted for 7 cycles after grant.
// 3 Round-robin: PEs 0,3,7 valid continuously, distinct free dests -> grant order 0,3,7,0,3,7 subject to holdoff; no PE starved.
// 4 Backpressure: rd_buffer_full_p[4][1]=1, PE1->4 valid -> no grant, stall_count increments per cycle (STATS on);
//   deassert -> grant next cycle.
// 5 Skid limit: PE1->4 always full=0, PE1 valid continuously -> inflight[4][1] peaks at <=4, never more than 4 grants
//   to (4,1) in any 8-cycle window.
// 6 Mid-op reset: assert rstn=0 one cycle after grant -> strobes drop to 0 immediately; counters cleared; no stale grant after release.

Source files
------------

// File: rtl/pe_bus_arbiter.sv
// Round-robin arbiter for the shared PE broadcast bus, compensating bus pipeline latency.
// Optional statistics counters are enabled by defining BUS_ARB_STATS_EN.
module pe_bus_arbiter #(
    parameter int unsigned NUM_PE       = 8,
    parameter int unsigned DATA_LEN     = 16,
    parameter int unsigned BUS_ADDR_LEN = 3,
    parameter int unsigned PIPE_STAGES  = 3,
    parameter int unsigned SKID_DEPTH   = 4
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [NUM_PE-1:0]                      valid_to_bus_p,
    input  logic [NUM_PE-1:0][BUS_ADDR_LEN-1:0]    addr_to_bus_p,
    input  logic [NUM_PE-1:0][DATA_LEN-1:0]        data_to_bus_p,
    input  logic [NUM_PE-1:0][NUM_PE-1:0]          rd_buffer_full_p,
    output logic [DATA_LEN-1:0]                    data_bus,
    output logic [BUS_ADDR_LEN-1:0]                addr_bus,
    output logic [NUM_PE-1:0]                      wr_to_bus,
    output logic [NUM_PE-1:0]                      rd_from_bus,
    output logic [31:0]                            grant_count,
    output logic [31:0]                            stall_count
);

    localparam int unsigned HOLDOFF = 2 * PIPE_STAGES + 1;
    localparam int unsigned RT_LAT  = 2 * PIPE_STAGES + 2;
    localparam int unsigned HO_W    = $clog2(HOLDOFF + 1);
    localparam int unsigned IF_W    = $clog2(SKID_DEPTH + 1);

    logic [BUS_ADDR_LEN-1:0]                          rr_ptr_q, rr_ptr_d;
    logic [NUM_PE-1:0][HO_W-1:0]                      holdoff_q, holdoff_d;
    logic [NUM_PE-1:0][NUM_PE-1:0][IF_W-1:0]          inflight_q, inflight_d;
    logic [RT_LAT-1:0]                                hist_vld_q, hist_vld_d;
    logic [RT_LAT-1:0][BUS_ADDR_LEN-1:0]              hist_dst_q, hist_dst_d;
    logic [RT_LAT-1:0][BUS_ADDR_LEN-1:0]              hist_src_q, hist_src_d;
    logic [DATA_LEN-1:0]                              data_bus_q, data_bus_d;
    logic [BUS_ADDR_LEN-1:0]                          addr_bus_q, addr_bus_d;
    logic [NUM_PE-1:0]                                wr_to_bus_q, wr_to_bus_d;
    logic [NUM_PE-1:0]                                rd_from_bus_q, rd_from_bus_d;

    logic [NUM_PE-1:0]       elig;
    logic                    gnt_vld;
    logic [BUS_ADDR_LEN-1:0] gnt_src;
    logic [BUS_ADDR_LEN-1:0] gnt_dst;
    logic [BUS_ADDR_LEN-1:0] rr_idx;

    // Eligibility and round-robin pick starting at rr_ptr
    always_comb begin
        elig    = '0;
        gnt_vld = 1'b0;
        gnt_src = '0;
        rr_idx  = '0;
        for (int unsigned s = 0; s < NUM_PE; s++) begin
            if (valid_to_bus_p[s] && (32'(addr_to_bus_p[s]) < NUM_PE) && (holdoff_q[s] == '0)) begin
                if (!rd_buffer_full_p[addr_to_bus_p[s]][s] &&
                    (32'(inflight_q[addr_to_bus_p[s]][s]) < SKID_DEPTH)) begin
                    elig[s] = 1'b1;
                end
            end
        end
        for (int unsigned k = 0; k < NUM_PE; k++) begin
            rr_idx = BUS_ADDR_LEN'((32'(rr_ptr_q) + k) % NUM_PE);
            if (!gnt_vld && elig[rr_idx]) begin
                gnt_vld = 1'b1;
                gnt_src = rr_idx;
            end
        end
        gnt_dst = addr_to_bus_p[gnt_src];
    end

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        holdoff_d     = holdoff_q;
        inflight_d    = inflight_q;
        data_bus_d    = data_bus_q;
        addr_bus_d    = addr_bus_q;
        wr_to_bus_d   = '0;
        rd_from_bus_d = '0;
        hist_vld_d    = {hist_vld_q[RT_LAT-2:0], gnt_vld};
        hist_dst_d    = {hist_dst_q[RT_LAT-2:0], gnt_dst};
        hist_src_d    = {hist_src_q[RT_LAT-2:0], gnt_src};

        if (gnt_vld) begin
            rr_ptr_d               = BUS_ADDR_LEN'((32'(gnt_src) + 1) % NUM_PE);
            data_bus_d             = data_to_bus_p[gnt_src];
            addr_bus_d             = gnt_src;
            wr_to_bus_d[gnt_dst]   = 1'b1;
            rd_from_bus_d[gnt_src] = 1'b1;
        end

        for (int unsigned s = 0; s < NUM_PE; s++) begin
            if (gnt_vld && (gnt_src == BUS_ADDR_LEN'(s))) begin
                holdoff_d[s] = HO_W'(HOLDOFF);
            end else if (holdoff_q[s] != '0) begin
                holdoff_d[s] = holdoff_q[s] - HO_W'(1);
            end
        end

        // Each grant occupies a skid slot until its round trip completes
        for (int unsigned d = 0; d < NUM_PE; d++) begin
            for (int unsigned s = 0; s < NUM_PE; s++) begin
                if (gnt_vld && (gnt_dst == BUS_ADDR_LEN'(d)) && (gnt_src == BUS_ADDR_LEN'(s))) begin
                    if (!(hist_vld_q[RT_LAT-1] && (hist_dst_q[RT_LAT-1] == BUS_ADDR_LEN'(d)) &&
                          (hist_src_q[RT_LAT-1] == BUS_ADDR_LEN'(s)))) begin
                        inflight_d[d][s] = inflight_q[d][s] + IF_W'(1);
                    end
                end else if (hist_vld_q[RT_LAT-1] && (hist_dst_q[RT_LAT-1] == BUS_ADDR_LEN'(d)) &&
                             (hist_src_q[RT_LAT-1] == BUS_ADDR_LEN'(s)) && (inflight_q[d][s] != '0)) begin
                    inflight_d[d][s] = inflight_q[d][s] - IF_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q      <= '0;
            holdoff_q     <= '0;
            inflight_q    <= '0;
            hist_vld_q    <= '0;
            hist_dst_q    <= '0;
            hist_src_q    <= '0;
            data_bus_q    <= '0;
            addr_bus_q    <= '0;
            wr_to_bus_q   <= '0;
            rd_from_bus_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            holdoff_q     <= holdoff_d;
            inflight_q    <= inflight_d;
            hist_vld_q    <= hist_vld_d;
            hist_dst_q    <= hist_dst_d;
            hist_src_q    <= hist_src_d;
            data_bus_q    <= data_bus_d;
            addr_bus_q    <= addr_bus_d;
            wr_to_bus_q   <= wr_to_bus_d;
            rd_from_bus_q <= rd_from_bus_d;
        end
    end

    assign data_bus    = data_bus_q;
    assign addr_bus    = addr_bus_q;
    assign wr_to_bus   = wr_to_bus_q;
    assign rd_from_bus = rd_from_bus_q;

`ifdef BUS_ARB_STATS_EN
    logic [31:0] grant_count_q, grant_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Saturating grant and stall statistics
    always_comb begin
        grant_count_d = grant_count_q;
        stall_count_d = stall_count_q;
        if (gnt_vld && (grant_count_q != '1)) begin
            grant_count_d = grant_count_q + 32'd1;
        end
        if (!gnt_vld && (|valid_to_bus_p) && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            grant_count_q <= grant_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign grant_count = grant_count_q;
    assign stall_count = stall_count_q;
`else
    assign grant_count = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pe_bus_arbiter.sv
// Testbench for pe_bus_arbiter: directed scenarios plus randomized traffic against a
// reference model that tracks grant times per source and per (dest,src) pair.
module tb_pe_bus_arbiter;

    localparam int NUM_PE       = 8;
    localparam int DATA_LEN     = 16;
    localparam int BUS_ADDR_LEN = 3;
    localparam int PIPE_STAGES  = 3;
    localparam int SKID_DEPTH   = 4;
    localparam int HOLDOFF      = 2 * PIPE_STAGES + 1;
    localparam int RT_LAT       = 2 * PIPE_STAGES + 2;

    logic                                clk = 1'b0;
    logic                                rstn;
    logic [NUM_PE-1:0]                   valid_to_bus_p;
    logic [NUM_PE-1:0][BUS_ADDR_LEN-1:0] addr_to_bus_p;
    logic [NUM_PE-1:0][DATA_LEN-1:0]     data_to_bus_p;
    logic [NUM_PE-1:0][NUM_PE-1:0]       rd_buffer_full_p;
    logic [DATA_LEN-1:0]                 data_bus;
    logic [BUS_ADDR_LEN-1:0]             addr_bus;
    logic [NUM_PE-1:0]                   wr_to_bus;
    logic [NUM_PE-1:0]                   rd_from_bus;
    logic [31:0]                         grant_count;
    logic [31:0]                         stall_count;

    pe_bus_arbiter #(
        .NUM_PE(NUM_PE), .DATA_LEN(DATA_LEN), .BUS_ADDR_LEN(BUS_ADDR_LEN),
        .PIPE_STAGES(PIPE_STAGES), .SKID_DEPTH(SKID_DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn),
        .valid_to_bus_p(valid_to_bus_p), .addr_to_bus_p(addr_to_bus_p),
        .data_to_bus_p(data_to_bus_p), .rd_buffer_full_p(rd_buffer_full_p),
        .data_bus(data_bus), .addr_bus(addr_bus),
        .wr_to_bus(wr_to_bus), .rd_from_bus(rd_from_bus),
        .grant_count(grant_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state
    typedef struct { int t; int d; int s; } grant_rec_t;
    grant_rec_t  glog[$];
    int          last_gnt [NUM_PE];
    int          m_rr;
    logic [DATA_LEN-1:0]     e_data;
    logic [BUS_ADDR_LEN-1:0] e_addr;
    logic [NUM_PE-1:0]       e_wr, e_rd;
    logic [31:0]             e_gc, e_sc;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic int m_inflight(int d, int s);
        int n = 0;
        foreach (glog[i]) if (glog[i].d == d && glog[i].s == s && (cyc - glog[i].t) <= RT_LAT) n++;
        return n;
    endfunction

    task automatic model_reset();
        glog.delete();
        foreach (last_gnt[i]) last_gnt[i] = -1000;
        m_rr = 0;
        e_data = '0; e_addr = '0; e_wr = '0; e_rd = '0; e_gc = '0; e_sc = '0;
    endtask

    // Decide this cycle's grant from the current inputs; results are due after the next edge
    task automatic model_step();
        int g = -1;
        int s, d;
        while (glog.size() > 0 && (cyc - glog[0].t) > RT_LAT) void'(glog.pop_front());
        for (int k = 0; k < NUM_PE; k++) begin
            s = (m_rr + k) % NUM_PE;
            d = int'(addr_to_bus_p[s]);
            if (g < 0 && valid_to_bus_p[s] && d < NUM_PE && (cyc - last_gnt[s]) > HOLDOFF &&
                !rd_buffer_full_p[d][s] && m_inflight(d, s) < SKID_DEPTH) g = s;
        end
        e_wr = '0;
        e_rd = '0;
        if (g >= 0) begin
            d = int'(addr_to_bus_p[g]);
            e_data = data_to_bus_p[g];
            e_addr = BUS_ADDR_LEN'(g);
            e_wr[d] = 1'b1;
            e_rd[g] = 1'b1;
            last_gnt[g] = cyc;
            glog.push_back('{t: cyc, d: d, s: g});
            m_rr = (g + 1) % NUM_PE;
            if (e_gc != 32'hFFFF_FFFF) e_gc++;
        end else if (|valid_to_bus_p) begin
            if (e_sc != 32'hFFFF_FFFF) e_sc++;
        end
    endtask

    task automatic check_outputs();
        check_val("wr_to_bus", 64'(wr_to_bus), 64'(e_wr));
        check_val("rd_from_bus", 64'(rd_from_bus), 64'(e_rd));
        check_val("data_bus", 64'(data_bus), 64'(e_data));
        check_val("addr_bus", 64'(addr_bus), 64'(e_addr));
`ifdef BUS_ARB_STATS_EN
        check_val("grant_count", 64'(grant_count), 64'(e_gc));
        check_val("stall_count", 64'(stall_count), 64'(e_sc));
`else
        check_val("grant_count", 64'(grant_count), 64'd0);
        check_val("stall_count", 64'(stall_count), 64'd0);
`endif
    endtask

    // One clock: model decides, DUT registers, outputs compared 1ns after the edge
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic clear_inputs();
        valid_to_bus_p   = '0;
        addr_to_bus_p    = '0;
        data_to_bus_p    = '0;
        rd_buffer_full_p = '0;
    endtask

    task automatic set_src(input int s, input int d, input logic [DATA_LEN-1:0] w);
        valid_to_bus_p[s] = 1'b1;
        addr_to_bus_p[s]  = BUS_ADDR_LEN'(d);
        data_to_bus_p[s]  = w;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rstn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int grant_times[$];
        int cnt;
        clear_inputs();
        model_reset();

        // Reset with valids asserted, then first grant from rr_ptr=0
        for (int s = 0; s < NUM_PE; s++) set_src(s, (s + 1) % NUM_PE, DATA_LEN'(16'h1000 + s));
        valid_to_bus_p = 8'b1010_0100;
        apply_reset();
        tick();
        check_val("first_grant_src", 64'(rd_from_bus), 64'h04);
        repeat (10) tick();

        // Single send with holdoff
        clear_inputs();
        apply_reset();
        set_src(2, 5, 16'hBEEF);
        tick();
        check_val("single_wr", 64'(wr_to_bus), 64'h20);
        check_val("single_rd", 64'(rd_from_bus), 64'h04);
        check_val("single_addr", 64'(addr_bus), 64'd2);
        check_val("single_data", 64'(data_bus), 64'hBEEF);
        for (int i = 0; i < HOLDOFF; i++) begin
            tick();
            check_val("holdoff_quiet", 64'(wr_to_bus), 64'h00);
        end
        tick();
        check_val("regrant_after_holdoff", 64'(wr_to_bus), 64'h20);

        // Round robin among 0,3,7
        clear_inputs();
        apply_reset();
        set_src(0, 1, 16'h0A0A);
        set_src(3, 2, 16'h3B3B);
        set_src(7, 5, 16'h7C7C);
        tick(); check_val("rr_first", 64'(addr_bus), 64'd0);
        tick(); check_val("rr_second", 64'(addr_bus), 64'd3);
        tick(); check_val("rr_third", 64'(addr_bus), 64'd7);
        repeat (20) tick();

        // Backpressure on (4,1)
        clear_inputs();
        apply_reset();
        set_src(1, 4, 16'h4141);
        rd_buffer_full_p[4][1] = 1'b1;
        repeat (6) tick();
        check_val("bp_no_grant", 64'(wr_to_bus), 64'h00);
        rd_buffer_full_p[4][1] = 1'b0;
        tick();
        check_val("bp_release_grant", 64'(wr_to_bus), 64'h10);

        // Skid limit on (4,1)
        clear_inputs();
        apply_reset();
        set_src(1, 4, 16'h5151);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wr_to_bus == 8'h10 && rd_from_bus == 8'h02) grant_times.push_back(cyc);
        end
        foreach (grant_times[i]) begin
            cnt = 0;
            foreach (grant_times[j]) if (grant_times[j] >= grant_times[i] && grant_times[j] < grant_times[i] + 8) cnt++;
            check_val("skid_window_le4", 64'(cnt <= SKID_DEPTH), 64'd1);
        end

        // Mid-operation reset right after a grant
        clear_inputs();
        apply_reset();
        set_src(5, 3, 16'hCAFE);
        tick();
        check_val("preabort_wr", 64'(wr_to_bus), 64'h08);
        rstn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (12) tick();

        // Randomized traffic
        clear_inputs();
        apply_reset();
        for (int i = 0; i < 500; i++) begin
            for (int s = 0; s < NUM_PE; s++) begin
                valid_to_bus_p[s] = ($urandom_range(0, 3) != 0);
                addr_to_bus_p[s]  = BUS_ADDR_LEN'($urandom_range(0, NUM_PE - 1));
                data_to_bus_p[s]  = DATA_LEN'($urandom);
                for (int d = 0; d < NUM_PE; d++) rd_buffer_full_p[d][s] = ($urandom_range(0, 7) == 0);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
